uart_transmitter: RTL and testbench

UART TX path: accepts parallel bytes through a valid/ready push interface into a small FIFO and serialises each byte as an 8N1-style frame on `Tx`. Frame format is one start bit (low), DATA_BITS data bits LSB first, then a stop bit (high). Bit timing is driven by the shared baud-rate generator's `Tick` pulse at 16 ticks per bit. It sits opposite the UART receiver on the same serial link and shares its tick source and oversampling convention.

---
 rtl/uart_transmitter_if.sv | 12 +
 rtl/uart_transmitter.sv | 177 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Byte push handshake between a data source and the UART transmitter.
// The source drives TxValid/TxData; the transmitter answers with TxReady (not full).
interface uart_transmitter_if #(
   parameter int DATA_BITS = 8
);
   logic                 TxValid;
   logic [DATA_BITS-1:0] TxData;
   logic                 TxReady;

   modport master (output TxValid, output TxData, input TxReady);
   modport slave  (input TxValid, input TxData, output TxReady);
endinterface

// File: rtl/uart_transmitter.sv
// UART TX path: a small byte FIFO feeding a start/data/stop serialiser.
// Bit timing comes from a shared 16x oversampling Tick.
module uart_transmitter #(
   parameter int DATA_BITS      = 8,
   parameter int STOP_BIT_TICKS = 16,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic              Clock,
   input  logic              ResetN,
   input  logic              Tick,
   uart_transmitter_if.slave tx_if,
   output logic              Tx,
   output logic              TxBusy,
   output logic              TxDone
);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam int TMAX = (STOP_BIT_TICKS > 16) ? STOP_BIT_TICKS : 16;
   localparam int TW   = $clog2(TMAX);
   localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [CW-1:0]        count_q, count_d;
   logic [PW-1:0]        wr_q, wr_d;
   logic [PW-1:0]        rd_q, rd_d;
   logic [DATA_BITS-1:0] fifo_q [FIFO_DEPTH];

   logic full_s, push_s, pop_s;

   // Pop only looks at the registered count, so a byte pushed into an empty FIFO leaves one edge later.
   assign full_s        = (count_q == CW'(FIFO_DEPTH));
   assign push_s        = tx_if.TxValid & ~full_s;
   assign pop_s         = (state_q == S_IDLE) && (count_q != CW'(0));
   assign tx_if.TxReady = ~full_s;

   // FIFO pointer and occupancy next-state.
   always_comb begin
      count_d = count_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      if (push_s) begin
         wr_d = wr_q + PW'(1);
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + PW'(1);
      end else begin
         rd_d = rd_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Serialiser next-state and registered line outputs.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (pop_s) begin
               shift_d = fifo_q[rd_q];
               tick_d  = '0;
               state_d = S_START;
               tx_d    = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (Tick && (tick_q == TW'(15))) begin
               tick_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
               tx_d    = shift_q[0];
            end else if (Tick) begin
               tick_d = tick_q + TW'(1);
            end else begin
               tick_d = tick_q;
            end
         end
         S_DATA: begin
            if (Tick && (tick_q == TW'(15))) begin
               tick_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_BITS - 1)) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + BW'(1);
                  tx_d  = shift_d[0];
               end
            end else if (Tick) begin
               tick_d = tick_q + TW'(1);
            end else begin
               tick_d = tick_q;
            end
         end
         S_STOP: begin
            if (Tick && (tick_q == TW'(STOP_BIT_TICKS - 1))) begin
               tick_d  = '0;
               state_d = S_IDLE;
               done_d  = 1'b1;
               tx_d    = 1'b1;
            end else if (Tick) begin
               tick_d = tick_q + TW'(1);
            end else begin
               tick_d = tick_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, counters and outputs; reset abandons any frame and empties the FIFO.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   // FIFO storage; validity is tracked by count_q, so the array itself needs no reset.
   always_ff @(posedge Clock) begin
      if (push_s) begin
         fifo_q[wr_q] <= tx_if.TxData;
      end
   end

   assign Tx     = tx_q;
   assign TxBusy = busy_q;
   assign TxDone = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: tick-indexed frame model checked every cycle,
// plus literal bit-sequence checks for fixed bytes and a 7-bit/32-tick-stop variant.
module tb_uart_transmitter;
   localparam int DB    = 8;
   localparam int ST    = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 16 * (1 + DB) + ST;

   logic Clock  = 1'b0;
   logic ResetN = 1'b0;
   logic Tick   = 1'b0;
   always #5 Clock = ~Clock;

   uart_transmitter_if #(.DATA_BITS(8)) bus ();
   uart_transmitter_if #(.DATA_BITS(7)) bus7 ();
   logic tx, busy, done, tx7, busy7, done7;

   uart_transmitter #(.DATA_BITS(8), .STOP_BIT_TICKS(16), .FIFO_DEPTH(4)) dut (
      .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .tx_if(bus.slave),
      .Tx(tx), .TxBusy(busy), .TxDone(done));

   uart_transmitter #(.DATA_BITS(7), .STOP_BIT_TICKS(32), .FIFO_DEPTH(4)) dut7 (
      .Clock(Clock), .ResetN(ResetN), .Tick(Tick), .tx_if(bus7.slave),
      .Tx(tx7), .TxBusy(busy7), .TxDone(done7));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO as a queue, frame as a count of consumed ticks.
   byte unsigned m_q[$];
   bit           m_active = 1'b0;
   int           m_ticks  = 0;
   logic [7:0]   m_byte   = 8'h00;
   bit           m_done   = 1'b0;
   bit           m_push, m_pop;

   initial forever begin
      @(posedge Clock or negedge ResetN);
      if (!ResetN) begin
         m_q.delete();
         m_active = 1'b0;
         m_ticks  = 0;
         m_done   = 1'b0;
      end else begin
         m_push = bus.TxValid && (m_q.size() < DEPTH);
         m_pop  = !m_active && (m_q.size() > 0);
         m_done = 1'b0;
         if (m_active && Tick) begin
            m_ticks++;
            if (m_ticks == FRAME) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
         if (m_pop) begin
            m_byte   = m_q.pop_front();
            m_active = 1'b1;
            m_ticks  = 0;
         end
         if (m_push) m_q.push_back(bus.TxData);
      end
   end

   function automatic logic model_tx();
      int b;
      if (!m_active) return 1'b1;
      b = m_ticks / 16;
      if (b == 0) return 1'b0;
      if (b <= DB) return m_byte[b-1];
      return 1'b1;
   endfunction

   int done_cnt  = 0;
   int done7_cnt = 0;

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge Clock);
      check("tx",    tx,          model_tx());
      check("busy",  busy,        m_active);
      check("done",  done,        m_done);
      check("ready", bus.TxReady, (m_q.size() < DEPTH));
      if (done)  done_cnt++;
      if (done7) done7_cnt++;
   end

   // Tick source: 0 off, 1 always, 2 periodic, 3 random.
   int tick_mode = 0;
   int tick_per  = 1;
   int tick_ph   = 0;
   initial forever begin
      @(posedge Clock);
      #1;
      case (tick_mode)
         0:       Tick = 1'b0;
         1:       Tick = 1'b1;
         2: begin
            tick_ph = (tick_ph + 1) % tick_per;
            Tick    = (tick_ph == 0);
         end
         default: Tick = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic push(input bit which, input logic [7:0] b, input int budget);
      int n;
      bit r, ok;
      n  = 0;
      ok = 1'b0;
      if (which) begin bus7.TxValid = 1'b1; bus7.TxData = b[6:0]; end
      else       begin bus.TxValid  = 1'b1; bus.TxData  = b;      end
      while (!ok && n < budget) begin
         @(negedge Clock);
         r = which ? bus7.TxReady : bus.TxReady;
         @(posedge Clock);
         #1;
         ok = r;
         n++;
      end
      check($sformatf("push_accept_%0h", b), ok, 1'b1);
   endtask

   task automatic wait_fall(input bit which, input int budget);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge Clock);
         seen = ((which ? tx7 : tx) == 1'b0);
         n++;
      end
      check("fall_seen", seen, 1'b1);
   endtask

   // With Tick tied high, Tx at the j-th negedge after the fall is bits[j/16]; TxDone at j=160.
   task automatic frame_check(input bit which, input logic [9:0] bits, input string lbl);
      logic t, d, bz;
      for (int j = 0; j <= 160; j++) begin
         t  = which ? tx7 : tx;
         d  = which ? done7 : done;
         bz = which ? busy7 : busy;
         check($sformatf("%s_bit_j%0d", lbl, j), t, (j < 160) ? bits[j/16] : 1'b1);
         check($sformatf("%s_done_j%0d", lbl, j), d, (j == 160));
         check($sformatf("%s_busy_j%0d", lbl, j), bz, (j < 160));
         if (j < 160) @(negedge Clock);
      end
   endtask

   logic [9:0] a5_bits = 10'b1101001010;
   logic [9:0] c3_bits = 10'b1001111000;
   logic [9:0] v7_bits = 10'b1110101010;

   initial begin
      int base, ticks, j, n, idx;
      bit got_done;
      bus.TxValid  = 1'b0; bus.TxData  = 8'h00;
      bus7.TxValid = 1'b0; bus7.TxData = 7'h00;

      // Reset held with random activity on the inputs.
      tick_mode = 3;
      for (int i = 0; i < 12; i++) begin
         step();
         bus.TxValid  = 1'($urandom_range(0, 1));
         bus.TxData   = 8'($urandom);
         bus7.TxValid = 1'($urandom_range(0, 1));
         bus7.TxData  = 7'($urandom);
         check("rst_tx", tx, 1'b1);
         check("rst_ready", bus.TxReady, 1'b1);
      end
      bus.TxValid = 1'b0; bus7.TxValid = 1'b0;
      step();
      ResetN = 1'b1;
      repeat (40) step();
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_no_done", done_cnt, 0);

      // Single byte 0xA5, Tick every 24 clocks.
      tick_mode = 2; tick_per = 24;
      step();
      base = done_cnt;
      push(1'b0, 8'hA5, 4);
      bus.TxValid = 1'b0;
      @(negedge Clock);
      check("lat_still_high", tx, 1'b1);
      @(negedge Clock);
      check("lat_fall", tx, 1'b0);
      ticks = 0; j = 0; got_done = 1'b0;
      while (!got_done && j < 6000) begin
         if (j >= 192 && ((j - 192) % 384) == 0 && ((j - 192) / 384) < 10) begin
            idx = (j - 192) / 384;
            check($sformatf("a5_bit%0d", idx), tx, a5_bits[idx]);
         end
         ticks += int'(Tick);
         @(negedge Clock);
         j++;
         if (done) got_done = 1'b1;
      end
      check("a5_done_seen", got_done, 1'b1);
      check("a5_ticks", ticks, 160);
      repeat (3) step();
      check("a5_done_count", done_cnt - base, 1);

      // Tick every cycle, 0x3C.
      tick_mode = 1;
      step();
      push(1'b0, 8'h3C, 4);
      bus.TxValid = 1'b0;
      wait_fall(1'b0, 10);
      frame_check(1'b0, c3_bits, "c3");
      step();

      // Back-to-back fill of six bytes.
      tick_mode = 2; tick_per = 2;
      step();
      base = done_cnt;
      for (int i = 1; i <= 5; i++) push(1'b0, 8'(i), 4);
      check("full_ready_low", bus.TxReady, 1'b0);
      push(1'b0, 8'h06, 3000);
      check("b6_after_first_frame", done_cnt - base, 1);
      bus.TxValid = 1'b0;
      n = 0;
      while ((done_cnt - base) < 6 && n < 6000) begin step(); n++; end
      check("b2b_frames", done_cnt - base, 6);
      repeat (4) step();

      // Reset during data bit 3 of 0xFF with two more bytes queued.
      push(1'b0, 8'hFF, 4);
      push(1'b0, 8'h11, 4);
      push(1'b0, 8'h22, 4);
      bus.TxValid = 1'b0;
      wait_fall(1'b0, 10);
      ticks = 0; n = 0;
      while (ticks < 72 && n < 1000) begin
         ticks += int'(Tick);
         @(negedge Clock);
         n++;
      end
      check("mid_busy_before", busy, 1'b1);
      base = done_cnt;
      @(posedge Clock);
      #2 ResetN = 1'b0;
      #1;
      check("async_tx", tx, 1'b1);
      check("async_busy", busy, 1'b0);
      check("async_ready", bus.TxReady, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         bus.TxValid = 1'($urandom_range(0, 1));
      end
      bus.TxValid = 1'b0;
      step();
      ResetN = 1'b1;
      repeat (500) step();
      check("post_rst_no_done", done_cnt - base, 0);
      check("post_rst_tx", tx, 1'b1);
      check("post_rst_busy", busy, 1'b0);

      // Randomised traffic against the model.
      tick_mode = 2; tick_per = $urandom_range(1, 3);
      for (int i = 0; i < 3000; i++) begin
         step();
         bus.TxValid = ($urandom_range(0, 3) == 0);
         bus.TxData  = 8'($urandom);
      end
      bus.TxValid = 1'b0;
      n = 0;
      while ((m_q.size() > 0 || m_active) && n < 5000) begin step(); n++; end
      check("rand_drained", (m_q.size() == 0 && !m_active), 1'b1);
      repeat (4) step();

      // Parameter variant: 7 data bits, 32-tick stop.
      tick_mode = 1;
      step();
      base = done7_cnt;
      push(1'b1, 8'h55, 4);
      bus7.TxValid = 1'b0;
      wait_fall(1'b1, 10);
      frame_check(1'b1, v7_bits, "v7");
      repeat (3) step();
      check("v7_done_count", done7_cnt - base, 1);
      check("v7_idle_tx", tx7, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
